// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer unit cells.
package serdes_pkg;

    localparam int SERDES_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } deser_state_t;

    // Returns the bit that makes data plus parity contain an even number of ones.
    function automatic logic even_parity(input logic [SERDES_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/deserializer_unit_cell_16_hold_reg.sv
// Holding register for recovered words: valid/ready handshake and overrun pulse.
module deser_hold_reg
    import serdes_pkg::*;
#(
    parameter int WIDTH = SERDES_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] word_in,
    input  logic             perr_in,
    input  logic             ready,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    output logic             perr,
    output logic             overrun
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word    <= '0;
            valid   <= 1'b0;
            perr    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                // A full register can take the new word only if the old one leaves this edge.
                if (!valid || ready) begin
                    word  <= word_in;
                    perr  <= perr_in;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/deserializer_unit_cell_16.sv
// Start-bit framed serial-to-parallel receiver with optional even parity.
module deserializer_unit_cell_16
    import serdes_pkg::*;
#(
    parameter int WIDTH     = SERDES_WIDTH,
    parameter bit PARITY_EN = 1'b1,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SERIAL_IN,
    output logic [WIDTH-1:0] PAR_OUT,
    output logic             PAR_VALID,
    input  logic             PAR_READY,
    output logic             PARITY_ERR,
    output logic             OVERRUN,
    output logic             BUSY
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    deser_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shift_next;
    logic             data_par;
    logic             commit;
    logic [WIDTH-1:0] commit_word;
    logic             commit_perr;

    if (LSB_FIRST) begin : g_lsb_first
        assign shift_next = {SERIAL_IN, sreg[WIDTH-1:1]};
    end else begin : g_msb_first
        assign shift_next = {sreg[WIDTH-2:0], SERIAL_IN};
    end

    if (WIDTH == SERDES_WIDTH) begin : g_pkg_par
        assign data_par = even_parity(sreg);
    end else begin : g_red_par
        assign data_par = ^sreg;
    end

    // Commit happens on the edge that samples the last bit of the frame.
    always_comb begin
        commit      = 1'b0;
        commit_word = shift_next;
        commit_perr = 1'b0;
        if (state == SHIFT && cnt == LAST_BIT && !PARITY_EN) begin
            commit = 1'b1;
        end
        if (state == PARITY) begin
            commit      = 1'b1;
            commit_word = sreg;
            commit_perr = data_par ^ SERIAL_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (SERIAL_IN) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    sreg <= shift_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= PARITY_EN ? PARITY : IDLE;
                    end
                end
                PARITY: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign BUSY = (state != IDLE);

    deser_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk     (CLK),
        .rst_n   (RESET),
        .load    (commit),
        .word_in (commit_word),
        .perr_in (commit_perr),
        .ready   (PAR_READY),
        .word    (PAR_OUT),
        .valid   (PAR_VALID),
        .perr    (PARITY_ERR),
        .overrun (OVERRUN)
    );

endmodule

// File: tb/tb_deserializer_unit_cell_16.sv
// Directed bench for deserializer_unit_cell_16: framing, parity, handshake, overrun, reset abort.
module tb_deserializer_unit_cell_16;
    import serdes_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        serial_in = 1'b0;
    logic        par_ready = 1'b0;
    logic [15:0] par_out;
    logic        par_valid;
    logic        parity_err;
    logic        overrun;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    deserializer_unit_cell_16 dut (
        .CLK        (clk),
        .RESET      (rst_n),
        .SERIAL_IN  (serial_in),
        .PAR_OUT    (par_out),
        .PAR_VALID  (par_valid),
        .PAR_READY  (par_ready),
        .PARITY_ERR (parity_err),
        .OVERRUN    (overrun),
        .BUSY       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drives start bit, 16 data bits MSB first, then parity; rdy_last >= 0 sets PAR_READY with the last bit.
    task automatic send_frame(input logic [15:0] w, input logic p, input int rdy_last);
        @(negedge clk);
        serial_in = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            serial_in = w[i];
        end
        @(negedge clk);
        if (rdy_last >= 0) par_ready = rdy_last[0];
        serial_in = p;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [15:0] w;
        logic [15:0] partial;
        int          stray_valid;

        // Reset and idle line
        repeat (2) @(negedge clk);
        check("reset_outs", 32'({par_out, par_valid, parity_err, overrun, busy}), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outs", 32'({par_out, par_valid, parity_err, overrun, busy}), 32'h0);
        end

        // Single frame, good parity
        par_ready = 1'b1;
        send_frame(16'hC5AF, 1'b0, -1);
        @(negedge clk);
        serial_in = 1'b0;
        check("single_out", 32'(par_out), 32'h0000C5AF);
        check("single_valid", 32'(par_valid), 32'h1);
        check("single_perr", 32'(parity_err), 32'h0);
        @(negedge clk);
        check("single_valid_1cyc", 32'(par_valid), 32'h0);

        // Same frame, wrong parity bit
        send_frame(16'hC5AF, 1'b1, -1);
        @(negedge clk);
        serial_in = 1'b0;
        check("perr_out", 32'(par_out), 32'h0000C5AF);
        check("perr_flag", 32'(parity_err), 32'h1);
        @(negedge clk);
        check("perr_consumed", 32'(par_valid), 32'h0);

        // Back-to-back with consumer stalled: second word dropped
        par_ready = 1'b0;
        send_frame(16'h1234, 1'b1, -1);
        send_frame(16'hFFFF, 1'b0, -1);
        @(negedge clk);
        serial_in = 1'b0;
        check("ovr_hold_out", 32'(par_out), 32'h00001234);
        check("ovr_valid", 32'(par_valid), 32'h1);
        check("ovr_perr", 32'(parity_err), 32'h0);
        check("ovr_pulse", 32'(overrun), 32'h1);
        @(negedge clk);
        check("ovr_pulse_end", 32'(overrun), 32'h0);
        check("ovr_still_out", 32'(par_out), 32'h00001234);
        par_ready = 1'b1;
        @(negedge clk);
        check("ovr_drain", 32'(par_valid), 32'h0);

        // Accept and commit on the same edge
        par_ready = 1'b0;
        send_frame(16'h1234, 1'b1, -1);
        send_frame(16'hA5C3, 1'b0, 1);
        @(negedge clk);
        serial_in = 1'b0;
        check("sim_out", 32'(par_out), 32'h0000A5C3);
        check("sim_valid", 32'(par_valid), 32'h1);
        check("sim_no_ovr", 32'(overrun), 32'h0);
        @(negedge clk);
        check("sim_drain", 32'(par_valid), 32'h0);

        // Reset after 8 data bits aborts the frame
        partial = 16'hBEEF;
        @(negedge clk);
        serial_in = 1'b1;
        for (int i = 15; i >= 8; i--) begin
            @(negedge clk);
            serial_in = partial[i];
        end
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        serial_in = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_valid", 32'(par_valid), 32'h0);
        rst_n = 1'b1;
        stray_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (par_valid || busy) stray_valid++;
        end
        check("abort_quiet", 32'(stray_valid), 32'h0);
        send_frame(16'h0F0F, 1'b0, -1);
        @(negedge clk);
        serial_in = 1'b0;
        check("after_abort_out", 32'(par_out), 32'h00000F0F);
        check("after_abort_valid", 32'(par_valid), 32'h1);
        check("after_abort_perr", 32'(parity_err), 32'h0);

        // Serializer-style stream of random words
        par_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            w = 16'($urandom);
            send_frame(w, even_parity(w), -1);
            @(negedge clk);
            serial_in = 1'b0;
            check("loop_out", 32'(par_out), 32'(w));
            check("loop_valid", 32'(par_valid), 32'h1);
            check("loop_perr", 32'(parity_err), 32'h0);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/deserializer_unit_cell_16.md
Name: deserializer_unit_cell_16

Overview:
Serial-to-parallel receive stage placed directly downstream of serializer_unit_cell_16. It consumes the serializer's one-bit-per-clock stream on SERIAL_IN and recovers 16-bit words using start-bit framing and an optional even-parity bit. Each recovered word is presented in a holding register with a valid/ready handshake to the next stage. Overrun and parity errors are flagged on dedicated outputs.

Parameters:
WIDTH, 16, number of data bits per frame.
PARITY_EN, 1, 1 means an even-parity bit follows the data bits; 0 means there is no parity bit.
LSB_FIRST, 0, 0 means data arrives MSB first; 1 means LSB first.

Ports:
CLK  input  1  clock; all logic is on the rising edge.
RESET  input  1  synchronous, active-low reset.
SERIAL_IN  input  1  serial line; idle level is 0.
PAR_OUT  output  WIDTH  recovered word, valid while PAR_VALID is high.
PAR_VALID  output  1  holding register is full.
PAR_READY  input  1  consumer accepts the word when PAR_VALID and PAR_READY are both high at a rising edge.
PARITY_ERR  output  1  parity result for the word in PAR_OUT; qualified by PAR_VALID.
OVERRUN  output  1  one-cycle pulse when a completed word is dropped.
BUSY  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset: the reset value applies at every rising edge where RESET is 0.
  - FSM goes to IDLE; bit count and shift register go to 0.
  - PAR_OUT, PAR_VALID, PARITY_ERR, OVERRUN and BUSY all go to 0.
  - Reset during a frame aborts it; the partial word is discarded.
- Frame format: start bit (1), then WIDTH data bits, then the parity bit if PARITY_EN=1. The frame is 18 cycles at the defaults.
- FSM states:
  - IDLE: if SERIAL_IN is 1 at an edge, go to SHIFT with the count cleared. The start bit is not stored. A 0 keeps the FSM in IDLE.
  - SHIFT: each edge shifts SERIAL_IN into the shift register (position per LSB_FIRST) and increments the count.
  - SHIFT exit: on the edge that samples data bit WIDTH-1, go to PARITY if PARITY_EN=1. Otherwise commit and go to IDLE.
  - PARITY: sample the parity bit, commit, and go to IDLE.
- Commit: occurs on the same edge that samples the final bit of the frame.
  - Latency: PAR_VALID and PAR_OUT update on that edge, so they are visible in the cycle after the last bit is on the line.
  - PARITY_ERR = XOR of all data bits XOR the parity bit. It is 0 when PARITY_EN=0.
- Back-to-back frames: the FSM is in IDLE in the cycle right after commit. A start bit in that cycle is accepted, so the line can run with no idle gap.
- Handshake: PAR_VALID stays high and PAR_OUT/PARITY_ERR stay stable until a rising edge with PAR_READY=1. At that edge PAR_VALID clears unless a commit occurs at the same edge.
- Commit with an empty holding register: load the word and set PAR_VALID.
- Commit with the holding register full and PAR_READY=1 at the same edge: the old word is consumed, the new word loads, PAR_VALID stays 1, and there is no overrun.
- Commit with the holding register full and PAR_READY=0:
  - The new word is dropped and the old word is kept.
  - OVERRUN is high for exactly the one cycle following that edge.
- PAR_READY is ignored while PAR_VALID is 0.
- The shift register is reused immediately after commit; the holding register is separate from it.
- Shift register contents during SHIFT are not observable on any output.

Decomposition:
- Package serdes_pkg holds:
  - localparam SERDES_WIDTH = 16;
  - the state enum deser_state_t {IDLE, SHIFT, PARITY};
  - function even_parity(logic [SERDES_WIDTH-1:0]).
- The serializer's testbench and future blocks share this package.
- One sub-module, deser_hold_reg, implements the holding register, valid/ready handshake and overrun pulse, parameterised by WIDTH.
- The FSM, shift register and counter stay in the top module.

Test Plan:
- Reset and idle: hold RESET=0 for 2 cycles, then drive SERIAL_IN=0 for 20 cycles. Required: all outputs stay 0; BUSY=0.
- Single frame: send 1, then 16'hC5AF MSB first, then parity 0, with PAR_READY=1. Required: PAR_OUT=16'hC5AF and PARITY_ERR=0 one cycle after the parity bit; PAR_VALID is high for exactly 1 cycle.
- Parity error: same frame with parity bit 1. Required: PAR_OUT=16'hC5AF and PARITY_ERR=1.
- Back-to-back with stall: send 16'h1234 then 16'hFFFF with no gap while PAR_READY=0. Required: PAR_OUT holds 16'h1234; OVERRUN pulses for 1 cycle; raising PAR_READY clears PAR_VALID on the next edge.
- Simultaneous accept and commit: PAR_READY=1 on the edge where the second word commits. Required: PAR_OUT becomes the second word, PAR_VALID stays 1, OVERRUN=0.
- Reset mid-frame, then loopback:
  - Assert RESET after 8 data bits. Required: BUSY=0 and no PAR_VALID; the next full frame is received correctly.
  - Connect serializer_unit_cell_16.SERIAL_OUT to SERIAL_IN for 10 $random words. Required: every PAR_OUT equals the corresponding PAR_IN and PARITY_ERR=0.
